fire_expand1_writeback: RTL and testbench
=========================================

FIRE_EXPAND1_WRITEBACK -- requirements
Module: fire_expand1_writeback

Interface
REQ-001 Parameter DSP_NO, default 64: number of parallel output lanes (channels) per pixel.
REQ-002 Parameter WIDTH, default 16: lane data width in bits, two's complement.
REQ-003 Parameter NPIX, default 4096: pixels per layer (WOUT*WOUT).
REQ-004 Parameter AW, default 18: write address width; must satisfy 2**AW >= NPIX*DSP_NO.
REQ-005 clk  input  1: single clock; all logic on its rising edge.
REQ-006 rst  input  1: asynchronous, active-low reset.
REQ-007 start  input  1: one-cycle pulse that begins a layer and clears counters, banks and flags.
REQ-008 sample  input  1: capture strobe from the expand stage; ofm_in is valid in this cycle.
REQ-009 ofm_in  input  DSP_NO x WIDTH (unpacked [0:DSP_NO-1]): parallel lane results for one pixel.
REQ-010 wr_en  output  1: RAM write strobe.
REQ-011 wr_addr  output  AW: RAM word address.
REQ-012 wr_data  output  WIDTH: RAM write data.
REQ-013 busy  output  1: a layer is active (after start, until done).
REQ-014 done  output  1: one-cycle pulse when the last word of the layer is written.
REQ-015 overflow  output  1: sticky; a sample was dropped.

Function
REQ-016 Two capture banks (A, B), each DSP_NO x WIDTH, ping-pong; sample writes ofm_in into the free bank, A preferred when both are free.
REQ-017 Captures are accepted only while busy=1; a sample with busy=0 is ignored and leaves overflow unchanged.
REQ-018 Drain order: banks are drained in capture order, lane 0 to lane DSP_NO-1, one word per cycle, wr_en=1 each drain cycle.
REQ-019 Latency: a sample in cycle t into an idle block gives the lane-0 write in cycle t+1 and the lane-(DSP_NO-1) write in cycle t+DSP_NO.
REQ-020 Back-to-back: when a second bank is full, its lane-0 write follows the previous bank's last write with no gap.
REQ-021 wr_addr = pix_cnt*DSP_NO + lane, where pix_cnt counts drained pixels from 0; pix_cnt increments after each bank's last write.
REQ-022 A bank is free again in the cycle its lane-(DSP_NO-1) write occurs; a sample in that same cycle is accepted into it.
REQ-023 A sample while both banks are full (not freeing this cycle) is dropped; overflow is set from the next cycle; bank contents are not altered.
REQ-024 Samples beyond NPIX accepted pixels are dropped and set overflow.
REQ-025 done pulses for one cycle, in the cycle after the last write of pixel NPIX-1; busy falls in that same cycle.
REQ-026 start while busy aborts: both banks are emptied, pix_cnt=0, overflow=0, wr_en=0 from the next cycle, busy stays 1.
REQ-027 A sample coincident with start is ignored.
REQ-028 wr_data and wr_addr hold their last value when wr_en=0.

Reset
REQ-029 rst=0 asynchronously forces wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, pix_cnt=0, lane=0, and both banks empty; bank data need not be cleared.
REQ-030 Reset mid-drain discards all pending data; after rst rises, nothing is written until start.

Configuration
REQ-031 Macro FIRE_WB_RELU_EN defined: wr_data = 0 when the bank word is negative (MSB=1), otherwise the word unchanged.
REQ-032 Macro FIRE_WB_RELU_EN undefined: wr_data is the bank word unchanged; latency is identical in both builds.

Verification
REQ-033 Reset, start, then one sample with lane i = i -> wr_en for 64 cycles starting at the cycle after sample, addr 0..63, data 0..63; busy stays 1.
REQ-034 Two samples 1 cycle apart (lanes = 16'h0100+i, then 16'h0200+i) -> 128 consecutive writes at addr 0..127, no gap, no overflow.
REQ-035 Three samples on consecutive cycles -> third is dropped, overflow=1 from the next cycle, exactly 128 writes; a sample in the cycle of write addr 63 is accepted as pixel 2 (addr 128..191).
REQ-036 NPIX=4 override: 4 samples spaced 70 cycles apart -> 256 writes, done one-cycle pulse after addr 255, busy=0; a 5th sample is ignored.
REQ-037 Lane value 16'hFFF0 -> wr_data 16'h0000 with FIRE_WB_RELU_EN, 16'hFFF0 without.
REQ-038 rst=0 asserted at write addr 30 -> all outputs 0 immediately; after release with no start, wr_en stays 0 for 100 cycles.

Source files
------------

// File: rtl/fire_expand1_writeback_if.sv
// Capture/write-back bus for fire_expand1_writeback.
// master: expand stage + RAM side (drives sample/ofm_in, observes the write port).
// slave:  the write-back block (consumes captures, drives the RAM write port).
interface fire_expand1_writeback_if #(
  parameter int unsigned DSP_NO = 64,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AW     = 18
);
  logic             sample;
  logic [WIDTH-1:0] ofm_in [0:DSP_NO-1];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output sample, output ofm_in, input wr_en, input wr_addr, input wr_data);
  modport slave  (input sample, input ofm_in, output wr_en, output wr_addr, output wr_data);
endinterface

// File: rtl/fire_expand1_writeback.sv
// Fire-module expand-1 write-back: captures one pixel of DSP_NO lane results
// into a ping-pong pair of banks and serialises them, one word per cycle,
// into a RAM at address pix*DSP_NO + lane.
// Optional feature: define FIRE_WB_RELU_EN to clamp negative words to zero.
module fire_expand1_writeback #(
  parameter int unsigned DSP_NO = 64,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NPIX   = 4096,
  parameter int unsigned AW     = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  fire_expand1_writeback_if.slave bus,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned LW = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int unsigned PW = $clog2(NPIX + 1);

  // Optional clamp on the outgoing word; same latency either way.
  function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] w);
`ifdef FIRE_WB_RELU_EN
    return w[WIDTH-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  logic [WIDTH-1:0] bank [2][DSP_NO];
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             cur;
  logic             oth;
  logic [LW-1:0]    lane;
  logic [PW-1:0]    pix_cnt;
  logic [PW-1:0]    acc_cnt;
  logic [AW-1:0]    wr_cnt;

  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;

  logic             last_wr;
  logic             free_a;
  logic             free_b;
  logic             sel;
  logic             req;
  logic             accept;
  logic             drop;
  logic             layer_end;
  logic             nxt_en;
  logic             nxt_bank;
  logic [LW-1:0]    nxt_lane;
  logic [WIDTH-1:0] nxt_word;

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign oth         = ~cur;

  // Capture arbitration and selection of the word written next cycle.
  always_comb begin
    last_wr   = wr_en_q && (lane == LW'(DSP_NO - 1));
    free_a    = !full[0] || (last_wr && (cur == 1'b0));
    free_b    = !full[1] || (last_wr && (cur == 1'b1));
    sel       = !free_a;
    req       = busy && bus.sample && !start;
    accept    = req && (acc_cnt < PW'(NPIX)) && (free_a || free_b);
    drop      = req && !accept;
    layer_end = last_wr && (pix_cnt == PW'(NPIX - 1));

    full_nxt = full;
    if (last_wr) full_nxt[cur] = 1'b0;
    if (accept)  full_nxt[sel] = 1'b1;

    nxt_en   = 1'b0;
    nxt_bank = cur;
    nxt_lane = lane;
    nxt_word = '0;
    if (wr_en_q && !last_wr) begin
      // continue current bank
      nxt_en   = 1'b1;
      nxt_lane = lane + LW'(1);
      nxt_word = bank[cur][nxt_lane];
    end else if (last_wr && full[oth]) begin
      // queued bank follows with no gap
      nxt_en   = 1'b1;
      nxt_bank = oth;
      nxt_lane = '0;
      nxt_word = bank[oth][0];
    end else if (accept) begin
      // idle path: lane 0 bypasses the bank so it is written next cycle
      nxt_en   = 1'b1;
      nxt_bank = sel;
      nxt_lane = '0;
      nxt_word = bus.ofm_in[0];
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      full      <= '0;
      cur       <= 1'b0;
      lane      <= '0;
      pix_cnt   <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      full     <= '0;
      cur      <= 1'b0;
      lane     <= '0;
      pix_cnt  <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      wr_en_q  <= 1'b0;
    end else begin
      done <= layer_end;
      if (layer_end) busy <= 1'b0;
      if (drop) overflow <= 1'b1;
      if (last_wr) pix_cnt <= pix_cnt + PW'(1);
      if (accept) acc_cnt <= acc_cnt + PW'(1);
      full    <= full_nxt;
      wr_en_q <= nxt_en;
      if (nxt_en) begin
        cur       <= nxt_bank;
        lane      <= nxt_lane;
        wr_addr_q <= wr_cnt;
        wr_cnt    <= wr_cnt + AW'(1);
        wr_data_q <= relu(nxt_word);
      end
    end
  end

  // Bank storage; contents are only meaningful while the bank is marked full.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < int'(DSP_NO); i++) begin
        bank[sel][i] <= bus.ofm_in[i];
      end
    end
  end

endmodule

// File: tb/tb_fire_expand1_writeback.sv
// Randomised bench for fire_expand1_writeback against a word-queue reference model.
module tb_fire_expand1_writeback;

  localparam int unsigned DSP_NO    = 64;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned NPIX      = 4;
  localparam int unsigned AW        = 18;
  localparam int unsigned LAST_ADDR = NPIX * DSP_NO - 1;

  typedef struct {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } wr_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic overflow;

  fire_expand1_writeback_if #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .AW(AW)) bus ();

  fire_expand1_writeback #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .NPIX(NPIX), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] ofm [DSP_NO];
  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  int n_done   = 0;

  // reference model: words still owed to the RAM, in order
  wr_t              q[$];
  bit               m_busy, m_done, m_ovf, m_en;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_data;
  int               m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [WIDTH-1:0] ref_word(input logic [WIDTH-1:0] v);
`ifdef FIRE_WB_RELU_EN
    return ($signed(v) < 0) ? WIDTH'(0) : v;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_done = 0; m_ovf = 0; m_en = 0;
    m_addr = '0; m_data = '0; m_acc = 0;
  endtask

  // Advance the model across one rising edge given that cycle's inputs.
  task automatic model_step(input bit s, input bit st);
    bit  fin;
    wr_t w;
    if (st) begin
      m_busy = 1; m_done = 0; m_ovf = 0; m_en = 0; m_acc = 0;
      q.delete();
      return;
    end
    fin = m_en && (m_addr == AW'(LAST_ADDR));
    if (m_busy && s) begin
      // at most two pixels may be resident; the one finishing now no longer counts
      if (m_acc < int'(NPIX) && q.size() <= int'(DSP_NO)) begin
        for (int i = 0; i < int'(DSP_NO); i++) begin
          w.a = AW'(m_acc * int'(DSP_NO) + i);
          w.d = ref_word(ofm[i]);
          q.push_back(w);
        end
        m_acc++;
      end else begin
        m_ovf = 1;
      end
    end
    if (q.size() > 0) begin
      w = q.pop_front();
      m_en = 1; m_addr = w.a; m_data = w.d;
    end else begin
      m_en = 0;
    end
    m_done = fin;
    if (fin) m_busy = 0;
  endtask

  task automatic compare_outputs();
    check("wr_en",    32'(bus.wr_en),   32'(m_en));
    check("wr_addr",  32'(bus.wr_addr), 32'(m_addr));
    check("wr_data",  32'(bus.wr_data), 32'(m_data));
    check("busy",     32'(busy),        32'(m_busy));
    check("done",     32'(done),        32'(m_done));
    check("overflow", 32'(overflow),    32'(m_ovf));
    n_wr   += int'(bus.wr_en);
    n_done += int'(done);
  endtask

  task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
    ofm[i] = v;
    bus.ofm_in[i] = v;
  endtask

  task automatic set_rand();
    for (int i = 0; i < int'(DSP_NO); i++) set_lane(i, WIDTH'($urandom));
  endtask

  task automatic tick(input bit s, input bit st);
    bus.sample = s;
    start = st;
    model_step(s, st);
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    bus.sample = 1'b0;
    for (int i = 0; i < int'(DSP_NO); i++) set_lane(i, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_outputs();
    rst = 1'b1;

    // single pixel: lane i = i
    for (int i = 0; i < int'(DSP_NO); i++) set_lane(i, WIDTH'(i));
    tick(0, 1);
    n_wr = 0;
    tick(1, 0);
    repeat (70) tick(0, 0);
    check("p1_writes", 32'(n_wr), 32'd64);
    check("p1_busy", 32'(busy), 32'd1);

    // two back-to-back pixels
    tick(0, 1);
    n_wr = 0;
    for (int i = 0; i < int'(DSP_NO); i++) set_lane(i, WIDTH'(16'h0100 + i));
    tick(1, 0);
    for (int i = 0; i < int'(DSP_NO); i++) set_lane(i, WIDTH'(16'h0200 + i));
    tick(1, 0);
    repeat (140) tick(0, 0);
    check("p2_writes", 32'(n_wr), 32'd128);
    check("p2_ovf", 32'(overflow), 32'd0);

    // third sample dropped; a sample on the addr-63 write cycle is taken
    tick(0, 1);
    n_wr = 0;
    for (int k = 0; k < 3; k++) begin
      set_rand();
      tick(1, 0);
    end
    for (int k = 0; k < 200 && !(bus.wr_en && bus.wr_addr == AW'(63)); k++) tick(0, 0);
    check("p3_at63", 32'(bus.wr_addr), 32'd63);
    set_rand();
    tick(1, 0);
    repeat (200) tick(0, 0);
    check("p3_writes", 32'(n_wr), 32'd192);
    check("p3_ovf", 32'(overflow), 32'd1);

    // full layer of NPIX pixels, then an ignored sample
    tick(0, 1);
    n_wr = 0;
    n_done = 0;
    for (int p = 0; p < int'(NPIX); p++) begin
      set_rand();
      tick(1, 0);
      repeat (69) tick(0, 0);
    end
    check("p4_writes", 32'(n_wr), 32'd256);
    check("p4_done", 32'(n_done), 32'd1);
    check("p4_busy", 32'(busy), 32'd0);
    set_rand();
    tick(1, 0);
    repeat (5) tick(0, 0);
    check("p4_ignored_ovf", 32'(overflow), 32'd0);
    check("p4_ignored_wr", 32'(n_wr), 32'd256);

    // negative word
    tick(0, 1);
    set_rand();
    set_lane(0, 16'hFFF0);
    tick(1, 0);
`ifdef FIRE_WB_RELU_EN
    check("relu_neg", 32'(bus.wr_data), 32'h0000);
`else
    check("relu_neg", 32'(bus.wr_data), 32'hFFF0);
`endif
    repeat (70) tick(0, 0);

    // random layers with occasional aborts
    for (int l = 0; l < 6; l++) begin
      int pct;
      pct = int'($urandom_range(5, 60));
      tick(0, 1);
      for (int c = 0; c < 400; c++) begin
        bit s, st;
        s  = ($urandom % 100) < pct;
        st = (l % 2 == 1) && ($urandom % 100 == 0);
        set_rand();
        tick(s, st);
      end
    end

    // reset in mid-drain
    tick(0, 1);
    set_rand();
    tick(1, 0);
    for (int k = 0; k < 100 && !(bus.wr_en && bus.wr_addr == AW'(30)); k++) tick(0, 0);
    check("p7_at30", 32'(bus.wr_addr), 32'd30);
    bus.sample = 1'b0;
    start = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_wr_en",   32'(bus.wr_en),   32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_ovf",     32'(overflow),    32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    n_wr = 0;
    repeat (100) begin
      set_rand();
      tick(1'($urandom % 2), 0);
    end
    check("p7_no_writes", 32'(n_wr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
